// File: rtl/morse_sequencer.sv
// Morse-code transmitter for letters A-Z: a ROM pattern is shifted out one unit per
// divider period, with start/busy/done handshake, optional repeat with a gap, and abort.
module morse_sequencer #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int UNIT_HZ   = 2,
    parameter int GAP_UNITS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] letter,
    input  logic       start,
    input  logic       repeat_en,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       morse_out,
    output logic       unit_tick
);

    localparam int DIV   = CLK_HZ / UNIT_HZ;
    localparam int DIV_W = $clog2(DIV);
    localparam int GAP_W = $clog2(GAP_UNITS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(DIV - 2);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_UNITS);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t             state;
    logic [12:0]        shift_reg;
    logic [3:0]         remaining;
    logic [GAP_W-1:0]   gap_cnt;
    logic [DIV_W-1:0]   div_cnt;

    logic [12:0]        rom_raw;
    logic [3:0]         rom_len;
    logic [12:0]        rom_pat;
    logic               letter_ok;
    logic               tick_now;

    // Patterns are written right-justified for readability and left-justified below.
    always_comb begin
        rom_raw = 13'b0;
        rom_len = 4'd1;
        case (letter)
            5'd0:  begin rom_raw = 13'b10111;         rom_len = 4'd5;  end
            5'd1:  begin rom_raw = 13'b111010101;     rom_len = 4'd9;  end
            5'd2:  begin rom_raw = 13'b11101011101;   rom_len = 4'd11; end
            5'd3:  begin rom_raw = 13'b1110101;       rom_len = 4'd7;  end
            5'd4:  begin rom_raw = 13'b1;             rom_len = 4'd1;  end
            5'd5:  begin rom_raw = 13'b101011101;     rom_len = 4'd9;  end
            5'd6:  begin rom_raw = 13'b111011101;     rom_len = 4'd9;  end
            5'd7:  begin rom_raw = 13'b1010101;       rom_len = 4'd7;  end
            5'd8:  begin rom_raw = 13'b101;           rom_len = 4'd3;  end
            5'd9:  begin rom_raw = 13'b1011101110111; rom_len = 4'd13; end
            5'd10: begin rom_raw = 13'b111010111;     rom_len = 4'd9;  end
            5'd11: begin rom_raw = 13'b101110101;     rom_len = 4'd9;  end
            5'd12: begin rom_raw = 13'b1110111;       rom_len = 4'd7;  end
            5'd13: begin rom_raw = 13'b11101;         rom_len = 4'd5;  end
            5'd14: begin rom_raw = 13'b11101110111;   rom_len = 4'd11; end
            5'd15: begin rom_raw = 13'b10111011101;   rom_len = 4'd11; end
            5'd16: begin rom_raw = 13'b1110111010111; rom_len = 4'd13; end
            5'd17: begin rom_raw = 13'b1011101;       rom_len = 4'd7;  end
            5'd18: begin rom_raw = 13'b10101;         rom_len = 4'd5;  end
            5'd19: begin rom_raw = 13'b111;           rom_len = 4'd3;  end
            5'd20: begin rom_raw = 13'b1010111;       rom_len = 4'd7;  end
            5'd21: begin rom_raw = 13'b101010111;     rom_len = 4'd9;  end
            5'd22: begin rom_raw = 13'b101110111;     rom_len = 4'd9;  end
            5'd23: begin rom_raw = 13'b11101010111;   rom_len = 4'd11; end
            5'd24: begin rom_raw = 13'b1110101110111; rom_len = 4'd13; end
            5'd25: begin rom_raw = 13'b1110111010101; rom_len = 4'd13; end
            default: begin rom_raw = 13'b0;           rom_len = 4'd1;  end
        endcase
        rom_pat   = rom_raw << (4'd13 - rom_len);
        letter_ok = (letter <= 5'd25);
        tick_now  = (div_cnt == DIV_LAST);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            remaining <= '0;
            gap_cnt   <= '0;
            div_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            morse_out <= 1'b0;
            unit_tick <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                remaining <= '0;
                gap_cnt   <= '0;
                div_cnt   <= '0;
                busy      <= 1'b0;
                morse_out <= 1'b0;
                unit_tick <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        div_cnt   <= '0;
                        unit_tick <= 1'b0;
                        if (start) begin
                            if (letter_ok) begin
                                shift_reg <= rom_pat;
                                remaining <= rom_len;
                                morse_out <= rom_pat[12];
                                busy      <= 1'b1;
                                err       <= 1'b0;
                                state     <= SEND;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    SEND, GAP: begin
                        // unit_tick is registered one cycle early so it lines up with div_cnt == DIV-1.
                        div_cnt   <= tick_now ? '0 : div_cnt + 1'b1;
                        unit_tick <= (div_cnt == DIV_PRE);
                        if (tick_now && state == SEND) begin
                            if (remaining == 4'd1) begin
                                morse_out <= 1'b0;
                                if (repeat_en) begin
                                    gap_cnt <= GAP_LOAD;
                                    state   <= GAP;
                                end else begin
                                    busy      <= 1'b0;
                                    done      <= 1'b1;
                                    unit_tick <= 1'b0;
                                    state     <= IDLE;
                                end
                            end else begin
                                shift_reg <= shift_reg << 1;
                                morse_out <= shift_reg[11];
                                remaining <= remaining - 4'd1;
                            end
                        end else if (tick_now && state == GAP) begin
                            if (gap_cnt == GAP_W'(1)) begin
                                if (letter_ok) begin
                                    shift_reg <= rom_pat;
                                    remaining <= rom_len;
                                    morse_out <= rom_pat[12];
                                    state     <= SEND;
                                end else begin
                                    err       <= 1'b1;
                                    busy      <= 1'b0;
                                    done      <= 1'b1;
                                    unit_tick <= 1'b0;
                                    state     <= IDLE;
                                end
                            end else begin
                                gap_cnt <= gap_cnt - 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_morse_sequencer.sv
// Directed bench for morse_sequencer: expected per-cycle outputs are queued from
// dot/dash strings when stimulus is driven and compared one cycle at a time.
module tb_morse_sequencer;

    localparam int DIV = 4;
    localparam int GAP = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] letter = 5'd0;
    logic       start = 1'b0;
    logic       repeat_en = 1'b0;
    logic       abort = 1'b0;
    logic       busy, done, err, morse_out, unit_tick;

    morse_sequencer #(.CLK_HZ(8), .UNIT_HZ(2), .GAP_UNITS(GAP)) dut (
        .clock     (clock),
        .reset     (reset),
        .letter    (letter),
        .start     (start),
        .repeat_en (repeat_en),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .morse_out (morse_out),
        .unit_tick (unit_tick)
    );

    always #5 clock = ~clock;

    // Vector layout: {morse_out, busy, unit_tick, done, err}
    logic [4:0] exp_q[$];
    logic       exp_err = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;

    function automatic string morse_str(int l);
        case (l)
            0: return ".-";    1: return "-...";  2: return "-.-.";  3: return "-..";
            4: return ".";     5: return "..-.";  6: return "--.";   7: return "....";
            8: return "..";    9: return ".---";  10: return "-.-";  11: return ".-..";
            12: return "--";   13: return "-.";   14: return "---";  15: return ".--.";
            16: return "--.-"; 17: return ".-.";  18: return "...";  19: return "-";
            20: return "..-";  21: return "...-"; 22: return ".--";  23: return "-..-";
            24: return "-.--"; 25: return "--..";
            default: return "";
        endcase
    endfunction

    function automatic void push_letter(int l);
        string s = morse_str(l);
        bit    bits[$];
        for (int i = 0; i < s.len(); i++) begin
            if (i > 0) bits.push_back(1'b0);
            if (s[i] == "-") begin
                bits.push_back(1'b1); bits.push_back(1'b1); bits.push_back(1'b1);
            end else begin
                bits.push_back(1'b1);
            end
        end
        for (int u = 0; u < bits.size(); u++)
            for (int c = 0; c < DIV; c++)
                exp_q.push_back({bits[u], 1'b1, (c == DIV - 1), 1'b0, exp_err});
    endfunction

    function automatic void push_gap();
        for (int c = 0; c < GAP * DIV; c++)
            exp_q.push_back({1'b0, 1'b1, ((c % DIV) == DIV - 1), 1'b0, exp_err});
    endfunction

    function automatic void push_done();
        exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1, exp_err});
    endfunction

    task automatic check(input string tag, input logic [4:0] expv);
        logic [4:0] obs;
        obs = {morse_out, busy, unit_tick, done, err};
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b (morse,busy,tick,done,err) t=%0t",
                   tag, obs, expv, $time);
        end
    endtask

    task automatic step(input string tag);
        logic [4:0] expv;
        @(posedge clock);
        #1;
        if (exp_q.size() > 0) expv = exp_q.pop_front();
        else expv = {4'b0000, exp_err};
        check(tag, expv);
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) step(tag);
    endtask

    initial begin
        #12;
        check("reset_state", 5'b00000);
        #1 reset = 1'b1;
        step("idle"); step("idle");

        // E: one dot, done at n+5
        letter = 5'd4; start = 1'b1;
        push_letter(4); push_done();
        step("E"); start = 1'b0;
        drain("E"); step("E_after");

        // Y: 13 units, done at n+53
        letter = 5'd24; start = 1'b1;
        push_letter(24); push_done();
        step("Y"); start = 1'b0;
        drain("Y"); step("Y_after");

        // T with repeat, repeat dropped during the second T
        letter = 5'd19; repeat_en = 1'b1; start = 1'b1;
        push_letter(19); push_gap(); push_letter(19); push_done();
        step("T_rep"); start = 1'b0;
        repeat (12 + 12 + 4 - 1) step("T_rep");
        repeat_en = 1'b0;
        drain("T_rep"); step("T_rep_after"); step("T_rep_after");

        // Invalid letter sets err, stays idle
        letter = 5'd27; start = 1'b1; exp_err = 1'b1;
        step("invalid"); start = 1'b0;
        step("invalid_idle"); step("invalid_idle");

        // A clears err, then E started in the done cycle
        letter = 5'd0; start = 1'b1; exp_err = 1'b0;
        push_letter(0); push_done();
        step("A"); start = 1'b0;
        while (exp_q.size() > 1) step("A");
        step("A_done");
        letter = 5'd4; start = 1'b1;
        push_letter(4); push_done();
        step("E_restart"); start = 1'b0;
        drain("E_restart"); step("E_restart_after");

        // Z aborted during cycle n+10
        letter = 5'd25; start = 1'b1;
        push_letter(25);
        exp_q = exp_q[0:9];
        step("Z_abort"); start = 1'b0;
        repeat (9) step("Z_abort");
        abort = 1'b1;
        step("abort_idle"); abort = 1'b0;
        step("abort_idle"); step("abort_idle");

        // start and abort together in IDLE
        letter = 5'd4; start = 1'b1; abort = 1'b1;
        step("start_abort"); start = 1'b0; abort = 1'b0;
        repeat (3) step("start_abort_idle");

        // Asynchronous reset mid-SEND
        letter = 5'd18; start = 1'b1;
        push_letter(18); push_done();
        step("S_pre_reset"); start = 1'b0;
        repeat (5) step("S_pre_reset");
        #3 reset = 1'b0;
        #1;
        exp_q.delete();
        check("async_reset", 5'b00000);
        @(posedge clock); #1;
        check("reset_held", 5'b00000);
        #2 reset = 1'b1;
        letter = 5'd18; start = 1'b1;
        push_letter(18); push_done();
        step("S_post_reset"); start = 1'b0;
        drain("S_post_reset"); step("S_after");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/morse_sequencer.md
# morse_sequencer

Parametrised Morse-code transmitter covering the full A–Z alphabet. It converts a 5-bit letter code into timed on/off units on a single LED-drive output. It contains its own unit-rate divider, which restarts on every accepted start, and a start/busy/done handshake. An optional repeat mode retransmits the letter with a programmable inter-letter gap. It sits between board switches/keys and an LEDR bit, and replaces the fixed S–Z, free-running-clock generator.

## Interface
- CLK_HZ, 50_000_000, input clock frequency in Hz.
- UNIT_HZ, 2, Morse units per second. DIV = CLK_HZ/UNIT_HZ (integer division); DIV ≥ 2 required.
- GAP_UNITS, 3, off-units inserted between repetitions in repeat mode; ≥ 1.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low; clears all state and outputs immediately.
- letter  in  5  0 = A … 25 = Z; 26–31 invalid.
- start  in  1  request; sampled each cycle, accepted only in IDLE.
- repeat  in  1  1 = loop the current letter until repeat drops or abort.
- abort  in  1  synchronous stop; highest priority after reset.
- busy  out  1  high in SEND and GAP.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  sticky invalid-letter flag; cleared by the next valid accepted start.
- morse_out  out  1  LED drive; 1 = tone on.
- unit_tick  out  1  one-cycle pulse at the last clock of each unit while busy.

## Operation
- Encoding: dot = 1 on-unit, dash = 3 on-units, 1 off-unit between symbols, no trailing off-unit. The pattern is stored MSB-first with length L in units.
- Examples: E = 1, L=1. T = 111, L=3. S = 10101, L=5. A = 10111, L=5. Y = 1110101110111, L=13.
- Max L = 13 (J, Q, Y, Z). The internal ROM holds a 13-bit left-justified pattern and a 4-bit length for each letter. The ROM is combinational; all outputs are registered.
- FSM states: IDLE, SEND, GAP. Reset state is IDLE.
- IDLE, start=1 with letter ≤ 25: load shift register and remaining count = L, clear the divider counter, clear err, go to SEND.
- IDLE, start=1 with letter > 25: set err, stay in IDLE; no done.
- SEND: morse_out = shift-register MSB. On unit_tick, shift left and decrement remaining. On the tick where remaining = 1:
  - repeat=1: go to GAP with gap count = GAP_UNITS.
  - repeat=0: go to IDLE and pulse done.
- GAP: morse_out = 0. After GAP_UNITS ticks, resample letter and reload:
  - Valid letter: go to SEND.
  - Invalid letter: set err, go to IDLE, pulse done.
- Divider: counts 0…DIV-1 only while busy; unit_tick fires when the count = DIV-1; the count is held at 0 in IDLE.
- start while busy: ignored. letter changes during SEND do not affect the letter in flight.
- abort=1 in any state: next cycle is IDLE with busy, morse_out, and unit_tick = 0; no done; err unchanged. If abort and start are both high in IDLE, abort wins.
- repeat deasserted mid-SEND: the current letter finishes, then done.
- Reset values: busy = done = err = morse_out = unit_tick = 0; all counters 0.

## Timing
- start accepted at cycle n: busy=1 and morse_out = first pattern bit from cycle n+1 (latency 1).
- Unit k (0-based) occupies cycles n+1+k·DIV … n+(k+1)·DIV; unit_tick is high at n+(k+1)·DIV.
- Non-repeat: done=1 and busy=0 at cycle n+L·DIV+1; morse_out=0 from then on.
- Repeat: gap spans cycles n+L·DIV+1 … n+(L+GAP_UNITS)·DIV. The next first unit starts at n+(L+GAP_UNITS)·DIV+1, with no dead cycle.
- Earliest restart: start in the done cycle is accepted (state is already IDLE).

## Test plan
- Use DIV=4 (CLK_HZ=8, UNIT_HZ=2), GAP_UNITS=3 throughout.
- Letter E, start pulse at n: morse_out high for cycles n+1…n+4; done at n+5; busy high for 4 cycles.
- Letter Y, no repeat: morse_out follows 1110101110111, 4 cycles per bit; 13 unit_ticks; done at n+53.
- Letter T with repeat=1 held: 111 for 12 cycles, 0 for 12 cycles, 111 again. Drop repeat during the 2nd T: done at the end of that T, with no 3rd gap.
- Letter 27 with start: err=1, busy stays 0, no done. Then letter A with start: err clears next cycle and A transmits normally.
- Letter Z, abort at n+10: at n+11 busy=0 and morse_out=0, no done. Also assert start and abort together in IDLE: no transmission.
- Reset low mid-SEND (asynchronous, between clock edges): all outputs 0 without waiting for an edge. After release, start sends the full letter from unit 0.
